// File: rtl/axi_xbar_cfg_ctrl_pkg.sv
// rtl/axi_xbar_cfg_ctrl_pkg.sv - shared types and width helpers for the crossbar config controller
package axi_xbar_cfg_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLOSE,
    DRAIN,
    COMMIT,
    REOPEN
  } state_e;

  typedef struct packed {
    logic [31:0] idx;
    logic [63:0] start_addr;
    logic [63:0] end_addr;
  } xbar_rule_64_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_trans);
    return unsigned'($clog2(max_trans + 1));
  endfunction

endpackage

// File: rtl/axi_xbar_cfg_ctrl_gate.sv
// rtl/axi_xbar_cfg_ctrl_gate.sv - axi_ax_gate: one valid/ready gate that closes only between beats
module axi_ax_gate (
  input  logic clk,
  input  logic rst,
  input  logic close_req,
  input  logic up_valid,
  input  logic xb_ready,
  output logic up_ready,
  output logic xb_valid,
  output logic closed
);

  logic closed_q;
  logic pending;

  assign xb_valid = up_valid & ~closed_q;
  assign up_ready = xb_ready & ~closed_q;
  assign pending  = xb_valid & ~xb_ready;
  // Reports "closed by the coming edge" so the controller need not wait an extra cycle.
  assign closed   = close_req & ~pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      closed_q <= 1'b0;
    end else if (!close_req) begin
      closed_q <= 1'b0;
    end else if (!pending) begin
      closed_q <= 1'b1;
    end
  end

endmodule

// File: rtl/axi_xbar_cfg_ctrl.sv
// rtl/axi_xbar_cfg_ctrl.sv - quiesce AW/AR, then atomically commit a new crossbar map (option: AXI_XBAR_CFG_CTRL_DRAIN_EN)
module axi_xbar_cfg_ctrl
  import axi_xbar_cfg_ctrl_pkg::*;
#(
  parameter int unsigned NoSlvPorts  = 2,
  parameter int unsigned NoMstPorts  = 4,
  parameter int unsigned NoAddrRules = 4,
  parameter type         rule_t      = xbar_rule_64_t,
  parameter int unsigned MaxTrans    = 8,
  localparam int unsigned MstIdxW    = idx_width(NoMstPorts),
  localparam int unsigned CntW       = cnt_width(MaxTrans)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  cfg_valid_i,
  output logic                                  cfg_ready_o,
  input  rule_t [NoAddrRules-1:0]               cfg_addr_map_i,
  input  logic  [NoSlvPorts-1:0]                cfg_en_default_i,
  input  logic  [NoSlvPorts-1:0][MstIdxW-1:0]   cfg_default_idx_i,
  output logic                                  cfg_done_o,
  output logic                                  busy_o,
  input  logic  [NoSlvPorts-1:0]                up_aw_valid_i,
  input  logic  [NoSlvPorts-1:0]                up_ar_valid_i,
  output logic  [NoSlvPorts-1:0]                up_aw_ready_o,
  output logic  [NoSlvPorts-1:0]                up_ar_ready_o,
  output logic  [NoSlvPorts-1:0]                xb_aw_valid_o,
  output logic  [NoSlvPorts-1:0]                xb_ar_valid_o,
  input  logic  [NoSlvPorts-1:0]                xb_aw_ready_i,
  input  logic  [NoSlvPorts-1:0]                xb_ar_ready_i,
  input  logic  [NoSlvPorts-1:0]                xb_b_hs_i,
  input  logic  [NoSlvPorts-1:0]                xb_rlast_hs_i,
  output rule_t [NoAddrRules-1:0]               addr_map_o,
  output logic  [NoSlvPorts-1:0]                en_default_mst_port_o,
  output logic  [NoSlvPorts-1:0][MstIdxW-1:0]   default_mst_port_o
);

  state_e                              state_q, state_d;
  rule_t [NoAddrRules-1:0]             map_shadow_q;
  logic  [NoSlvPorts-1:0]              en_shadow_q;
  logic  [NoSlvPorts-1:0][MstIdxW-1:0] idx_shadow_q;
  logic  [2*NoSlvPorts-1:0]            closed;
  logic                                close_req;
  logic                                drained;

`ifdef AXI_XBAR_CFG_CTRL_DRAIN_EN
  localparam bit DrainEn = 1'b1;
  logic [NoSlvPorts-1:0][CntW-1:0] aw_cnt_q, ar_cnt_q;
  logic [NoSlvPorts-1:0]           aw_hs, ar_hs;

  assign aw_hs   = xb_aw_valid_o & xb_aw_ready_i;
  assign ar_hs   = xb_ar_valid_o & xb_ar_ready_i;
  assign drained = (aw_cnt_q == '0) && (ar_cnt_q == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_cnt_q <= '0;
      ar_cnt_q <= '0;
    end else begin
      for (int p = 0; p < NoSlvPorts; p++) begin
        if (aw_hs[p] && !xb_b_hs_i[p])          aw_cnt_q[p] <= aw_cnt_q[p] + 1'b1;
        else if (!aw_hs[p] && xb_b_hs_i[p])     aw_cnt_q[p] <= aw_cnt_q[p] - 1'b1;
        if (ar_hs[p] && !xb_rlast_hs_i[p])      ar_cnt_q[p] <= ar_cnt_q[p] + 1'b1;
        else if (!ar_hs[p] && xb_rlast_hs_i[p]) ar_cnt_q[p] <= ar_cnt_q[p] - 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i) begin
      for (int p = 0; p < NoSlvPorts; p++) begin
        assert (!(aw_hs[p] && !xb_b_hs_i[p] && aw_cnt_q[p] == CntW'(MaxTrans)));
        assert (!(!aw_hs[p] && xb_b_hs_i[p] && aw_cnt_q[p] == '0));
        assert (!(ar_hs[p] && !xb_rlast_hs_i[p] && ar_cnt_q[p] == CntW'(MaxTrans)));
        assert (!(!ar_hs[p] && xb_rlast_hs_i[p] && ar_cnt_q[p] == '0));
      end
    end
  end
`endif
`else
  localparam bit DrainEn = 1'b0;
  logic            unused_hs;
  logic [CntW-1:0] unused_cnt;
  assign drained    = 1'b1;
  assign unused_hs  = ^{xb_b_hs_i, xb_rlast_hs_i};
  assign unused_cnt = '0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cfg_valid_i) state_d = CLOSE;
      CLOSE:   if (&closed)     state_d = DrainEn ? DRAIN : COMMIT;
      DRAIN:   if (drained)     state_d = COMMIT;
      COMMIT:  state_d = REOPEN;
      REOPEN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready_o = (state_q == IDLE);
    cfg_done_o  = (state_q == COMMIT);
    busy_o      = (state_q != IDLE);
    close_req   = (state_q == CLOSE) || (state_q == DRAIN) || (state_q == COMMIT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      map_shadow_q <= '0;
      en_shadow_q  <= '0;
      idx_shadow_q <= '0;
    end else if (cfg_valid_i && state_q == IDLE) begin
      map_shadow_q <= cfg_addr_map_i;
      en_shadow_q  <= cfg_en_default_i;
      idx_shadow_q <= cfg_default_idx_i;
    end
  end

  // Active map only moves on the COMMIT edge, while every gate is closed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_map_o            <= '0;
      en_default_mst_port_o <= '0;
      default_mst_port_o    <= '0;
    end else if (state_q == COMMIT) begin
      addr_map_o            <= map_shadow_q;
      en_default_mst_port_o <= en_shadow_q;
      default_mst_port_o    <= idx_shadow_q;
    end
  end

  for (genvar p = 0; p < NoSlvPorts; p++) begin : g_port
    axi_ax_gate i_aw_gate (
      .clk       (clk_i),
      .rst       (rst_i),
      .close_req (close_req),
      .up_valid  (up_aw_valid_i[p]),
      .xb_ready  (xb_aw_ready_i[p]),
      .up_ready  (up_aw_ready_o[p]),
      .xb_valid  (xb_aw_valid_o[p]),
      .closed    (closed[2*p])
    );
    axi_ax_gate i_ar_gate (
      .clk       (clk_i),
      .rst       (rst_i),
      .close_req (close_req),
      .up_valid  (up_ar_valid_i[p]),
      .xb_ready  (xb_ar_ready_i[p]),
      .up_ready  (up_ar_ready_o[p]),
      .xb_valid  (xb_ar_valid_o[p]),
      .closed    (closed[2*p+1])
    );
  end

endmodule

// File: tb/tb_axi_xbar_cfg_ctrl.sv
// tb/tb_axi_xbar_cfg_ctrl.sv - directed scoreboard bench for axi_xbar_cfg_ctrl
module tb_axi_xbar_cfg_ctrl;
  import axi_xbar_cfg_ctrl_pkg::*;

  typedef struct packed {
    xbar_rule_64_t [3:0] map;
    logic [1:0]          en;
    logic [1:0][1:0]     idx;
  } cfg_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_valid = 1'b0, cfg_ready, cfg_done, busy;
  xbar_rule_64_t [3:0] cfg_addr_map = '0, addr_map;
  logic [1:0] cfg_en_default = '0, en_default;
  logic [1:0][1:0] cfg_default_idx = '0, default_idx;
  logic [1:0] up_aw_valid = '0, up_ar_valid = '0, up_aw_ready, up_ar_ready;
  logic [1:0] xb_aw_valid, xb_ar_valid;
  logic [1:0] xb_aw_ready = '0, xb_ar_ready = '0, xb_b_hs = '0, xb_rlast_hs = '0;

  int vectors = 0;
  int fails = 0;
  cfg_t exp_q[$];
  cfg_t c_a, c_b, c_c, c_d, c_e, c_f, c_g, c_h;

  axi_xbar_cfg_ctrl dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .cfg_valid_i           (cfg_valid),
    .cfg_ready_o           (cfg_ready),
    .cfg_addr_map_i        (cfg_addr_map),
    .cfg_en_default_i      (cfg_en_default),
    .cfg_default_idx_i     (cfg_default_idx),
    .cfg_done_o            (cfg_done),
    .busy_o                (busy),
    .up_aw_valid_i         (up_aw_valid),
    .up_ar_valid_i         (up_ar_valid),
    .up_aw_ready_o         (up_aw_ready),
    .up_ar_ready_o         (up_ar_ready),
    .xb_aw_valid_o         (xb_aw_valid),
    .xb_ar_valid_o         (xb_ar_valid),
    .xb_aw_ready_i         (xb_aw_ready),
    .xb_ar_ready_i         (xb_ar_ready),
    .xb_b_hs_i             (xb_b_hs),
    .xb_rlast_hs_i         (xb_rlast_hs),
    .addr_map_o            (addr_map),
    .en_default_mst_port_o (en_default),
    .default_mst_port_o    (default_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic cfg_t rand_cfg();
    cfg_t c;
    for (int r = 0; r < 4; r++) begin
      c.map[r].idx        = $urandom;
      c.map[r].start_addr = {$urandom, $urandom};
      c.map[r].end_addr   = {$urandom, $urandom};
    end
    c.en  = 2'($urandom);
    c.idx = 4'($urandom);
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cfg(input cfg_t c, input logic v);
    cfg_valid       = v;
    cfg_addr_map    = c.map;
    cfg_en_default  = c.en;
    cfg_default_idx = c.idx;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!cfg_ready && n < 40) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, cfg_ready}, 32'd1);
  endtask

  // Commit scoreboard: the cycle after cfg_done the active outputs must equal
  // the oldest expected config; at every other sample they must not move.
  logic done_d = 1'b0;
  logic prev_ok = 1'b0;
  cfg_t prev, cur, e;
  always @(negedge clk) begin
    cur = {addr_map, en_default, default_idx};
    if (rst) begin
      prev_ok = 1'b0;
    end else if (done_d) begin
      if (exp_q.size() == 0) begin
        chk("commit_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("commit_value", cur, e);
      end
    end else if (prev_ok) begin
      chk("outputs_stable", cur, prev);
    end
    if (!rst) prev_ok = 1'b1;
    done_d = cfg_done & ~rst;
    prev   = cur;
  end

  initial begin
    c_a = rand_cfg(); c_b = rand_cfg(); c_c = rand_cfg(); c_d = rand_cfg();
    c_e = rand_cfg(); c_f = rand_cfg(); c_g = rand_cfg(); c_h = rand_cfg();

    // Reset state and pass-through while in reset
    #1;
    up_aw_valid = 2'b01; xb_aw_ready = 2'b11;
    #1;
    chk("rst_ready", {31'd0, cfg_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, cfg_done}, 32'd0);
    chk("rst_active", {addr_map, en_default, default_idx}, '0);
    chk("rst_aw_pass", {30'd0, xb_aw_valid}, 32'd1);
    chk("rst_aw_ready", {30'd0, up_aw_ready}, 32'd3);
    up_aw_valid = '0; xb_aw_ready = '0;
    tick(); tick();
    rst = 1'b0;

    // 1: idle bus, accept -> done 2 cycles later -> busy clears
    tick();
    drive_cfg(c_a, 1'b1);
    #1 chk("t1_accept_ready", {31'd0, cfg_ready}, 32'd1);
    exp_q.push_back(c_a);
    tick();
    cfg_valid = 1'b0;
    #1 chk("t1_busy_set", {31'd0, busy}, 32'd1);
    chk("t1_ready_low", {31'd0, cfg_ready}, 32'd0);
    chk("t1_done_early", {31'd0, cfg_done}, 32'd0);
    tick();
    chk("t1_done", {31'd0, cfg_done}, 32'd1);
    tick();
    chk("t1_done_pulse", {31'd0, cfg_done}, 32'd0);
    chk("t1_map", addr_map, c_a.map);
    chk("t1_busy_reopen", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_busy_clear", {31'd0, busy}, 32'd0);

    // 2: pending AW on port 0 holds CLOSE until its handshake
    up_aw_valid = 2'b01; xb_aw_ready = 2'b00;
    drive_cfg(c_b, 1'b1);
    exp_q.push_back(c_b);
    tick();
    cfg_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("t2_held_valid", {30'd0, xb_aw_valid}, 32'd1);
      chk("t2_no_done", {31'd0, cfg_done}, 32'd0);
      tick();
    end
    xb_aw_ready = 2'b01;
    #1 chk("t2_hs_ready", {30'd0, up_aw_ready}, 32'd1);
    chk("t2_no_done_hs", {31'd0, cfg_done}, 32'd0);
    tick();
    chk("t2_gate_closed", {30'd0, xb_aw_valid}, 32'd0);
    chk("t2_up_ready_closed", {30'd0, up_aw_ready}, 32'd0);
    chk("t2_done_after_hs", {31'd0, cfg_done}, 32'd1);
    tick();
    chk("t2_reopen_closed", {30'd0, xb_aw_valid}, 32'd0);
    tick();
    chk("t2_pass_again", {30'd0, xb_aw_valid}, 32'd1);
    up_aw_valid = '0; xb_aw_ready = '0;

    // 3: AR on port 1 blocked while closed, passes after REOPEN
    xb_ar_ready = 2'b11;
    drive_cfg(c_c, 1'b1);
    exp_q.push_back(c_c);
    tick();
    cfg_valid = 1'b0;
    tick();
    up_ar_valid = 2'b10;
    #1 chk("t3_ar_blocked", {28'd0, xb_ar_valid, up_ar_ready}, 32'd0);
    tick();
    chk("t3_ar_blocked_reopen", {28'd0, xb_ar_valid, up_ar_ready}, 32'd0);
    tick();
    chk("t3_ar_pass", {30'd0, xb_ar_valid}, 32'd2);
    chk("t3_ar_ready", {30'd0, up_ar_ready}, 32'd3);
    up_ar_valid = '0; xb_ar_ready = '0;

`ifdef AXI_XBAR_CFG_CTRL_DRAIN_EN
    // 4: three AWs plus one AW+B overlap; commit one cycle after last B
    up_aw_valid = 2'b01; xb_aw_ready = 2'b01;
    tick(); tick(); tick();
    xb_b_hs = 2'b01;
    tick();
    up_aw_valid = '0; xb_aw_ready = '0; xb_b_hs = '0;
    drive_cfg(c_g, 1'b1);
    exp_q.push_back(c_g);
    tick();
    cfg_valid = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        #1 chk("t4_drain_wait", {31'd0, cfg_done}, 32'd0);
        tick();
      end
      xb_b_hs = 2'b01;
      #1 chk("t4_drain_b", {31'd0, cfg_done}, 32'd0);
      tick();
      xb_b_hs = '0;
    end
    #1 chk("t4_zero_cycle", {31'd0, cfg_done}, 32'd0);
    tick();
    chk("t4_commit", {31'd0, cfg_done}, 32'd1);
    wait_idle("t4_idle");
`endif

    // 5: reset while stuck in CLOSE discards the config
    up_aw_valid = 2'b10; xb_aw_ready = 2'b00;
    drive_cfg(c_d, 1'b1);
    tick();
    cfg_valid = 1'b0;
    #1 chk("t5_busy_close", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1 chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_ready", {31'd0, cfg_ready}, 32'd1);
    chk("t5_rst_active", {addr_map, en_default, default_idx}, '0);
    chk("t5_rst_pass", {30'd0, xb_aw_valid}, 32'd2);
    tick();
    rst = 1'b0;
    up_aw_valid = '0;
    tick();
    drive_cfg(c_e, 1'b1);
    exp_q.push_back(c_e);
    tick();
    cfg_valid = 1'b0;
    wait_idle("t5_after_reset");
    chk("t5_new_map", addr_map, c_e.map);

    // 6: cfg_valid held with changing data; second value taken in next IDLE
    drive_cfg(c_f, 1'b1);
    exp_q.push_back(c_f);
    tick();
    drive_cfg(c_g, 1'b1);
    #1 chk("t6_ready_busy", {31'd0, cfg_ready}, 32'd0);
    tick();
    drive_cfg(c_h, 1'b1);
    tick(); tick();
    chk("t6_ready_again", {31'd0, cfg_ready}, 32'd1);
    exp_q.push_back(c_h);
    tick();
    cfg_valid = 1'b0;
    wait_idle("t6_idle");
    chk("t6_final_map", addr_map, c_h.map);
    tick();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
